// File: rtl/boot_pkg.sv
// Shared definitions for both ends of the UART boot link: FSM states,
// 8N1 frame constants and the image checksum rule.
package boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP, S_DONE, S_CKSUM
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = DATA_BITS + 2;

  // Checksum byte makes image bytes plus checksum sum to zero mod 256.
  function automatic logic [7:0] cksum(input logic [7:0] sum);
    return 8'(~sum + 8'd1);
  endfunction

endpackage

// File: rtl/boot_image_sender_if.sv
// Synchronous-read image memory port: read data is valid the cycle after mem_rd_en.
interface boot_image_sender_if #(
  parameter int ADDR_W = 8
) ();
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (output mem_rd_en, mem_addr, input mem_data);
  modport slave  (input mem_rd_en, mem_addr, output mem_data);
endinterface

// File: rtl/uart_tx_shift.sv
// 8N1 serializer: baud counter, bit counter and shift register behind a
// load/busy handshake. A load on the final stop-bit cycle chains frames gaplessly.
module uart_tx_shift
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       tick,
  output logic [3:0] bit_idx
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        STOP_IDX  = 4'(FRAME_BITS - 1);
  localparam logic [3:0]        LAST_DATA = 4'(DATA_BITS);

  logic [BAUD_W-1:0] baud;
  logic [7:0]        shift;

  // bit_idx: 0 start, 1..8 data, 9 stop; tick marks the last cycle of a bit
  assign tick = ce && busy && (baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= STOP_BIT;
      busy    <= 1'b0;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else if (ce) begin
      if (load) begin
        shift   <= data;
        tx      <= START_BIT;
        busy    <= 1'b1;
        baud    <= '0;
        bit_idx <= '0;
      end else if (busy) begin
        if (baud == BAUD_LAST) begin
          baud <= '0;
          if (bit_idx == STOP_IDX) begin
            busy <= 1'b0;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == LAST_DATA) begin
              tx <= STOP_BIT;
            end else begin
              tx    <= shift[0];
              shift <= {1'b0, shift[7:1]};
            end
          end
        end else begin
          baud <= baud + BAUD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/boot_image_sender.sv
// UART boot image transmitter: fetches IMAGE_LEN bytes and sends them as 8N1 frames.
// Optional trailing checksum frame: define BOOT_IMAGE_SENDER_CHECKSUM_EN.
module boot_image_sender
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 8,
  parameter int IMAGE_LEN    = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                start,
  output logic                tx,
  output logic                busy,
  output logic                done,
  boot_image_sender_if.master mem
);

  // One extra counter bit so IMAGE_LEN == 2**ADDR_W needs no wrap.
  localparam int             CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(IMAGE_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] byte_cnt;
  logic             sh_busy;
  logic             tick;
  logic [3:0]       bit_idx;
  logic             load;
  logic [7:0]       load_data;
  logic             last_byte;
  logic             frame_end;

  assign last_byte = (byte_cnt == LAST_BYTE);
  assign frame_end = tick && (bit_idx == 4'(FRAME_BITS - 1));

`ifdef BOOT_IMAGE_SENDER_CHECKSUM_EN
  logic [7:0] sum;

  // Checksum frame is loaded on the last image stop-bit cycle, so it follows without a gap.
  always_comb begin
    load      = 1'b0;
    load_data = mem.mem_data;
    if (ce && state == S_LOAD && !sh_busy) begin
      load = 1'b1;
    end else if (state == S_STOP && frame_end && last_byte) begin
      load      = 1'b1;
      load_data = cksum(sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          sum <= '0;
    else if (ce && state == S_IDLE)      sum <= '0;
    else if (load && state == S_LOAD)    sum <= sum + mem.mem_data;
  end
`else
  assign load      = ce && state == S_LOAD && !sh_busy;
  assign load_data = mem.mem_data;
`endif

  uart_tx_shift #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce     (ce),
    .load   (load),
    .data   (load_data),
    .tx     (tx),
    .busy   (sh_busy),
    .tick   (tick),
    .bit_idx(bit_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      byte_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem.mem_rd_en <= 1'b0;
      mem.mem_addr  <= '0;
    end else if (ce) begin
      case (state)
        S_IDLE: if (start) begin
          state         <= S_FETCH;
          byte_cnt      <= '0;
          busy          <= 1'b1;
          mem.mem_rd_en <= 1'b1;
          mem.mem_addr  <= '0;
        end
        S_FETCH: begin
          state         <= S_LOAD;
          mem.mem_rd_en <= 1'b0;
        end
        S_LOAD:  if (!sh_busy) state <= S_START;
        S_START: if (tick) state <= S_DATA;
        S_DATA:  if (tick && bit_idx == 4'(DATA_BITS)) state <= S_STOP;
        S_STOP: if (frame_end) begin
          if (!last_byte) begin
            byte_cnt      <= byte_cnt + CNT_W'(1);
            state         <= S_FETCH;
            mem.mem_rd_en <= 1'b1;
            mem.mem_addr  <= ADDR_W'(byte_cnt + CNT_W'(1));
          end else begin
`ifdef BOOT_IMAGE_SENDER_CHECKSUM_EN
            state <= S_CKSUM;
`else
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end
        end
        S_CKSUM: if (frame_end) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_image_sender.sv
// Directed bench for boot_image_sender: a UART decoder on tx feeds a byte
// scoreboard; timing, ce gating, restart and async reset are checked inline.
module tb_boot_image_sender;

  localparam int CPB = 4;
  localparam int AW  = 8;
  localparam int LEN = 3;
`ifdef BOOT_IMAGE_SENDER_CHECKSUM_EN
  localparam int NFR = LEN + 1;
`else
  localparam int NFR = LEN;
`endif
  localparam int FRAME_CYC = 10 * CPB + 2;
  localparam int DONE_CYC  = 1 + LEN * FRAME_CYC + (NFR - LEN) * 10 * CPB;

  typedef struct {
    logic [7:0] data;
    bit         ok;
    int         t;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n, ce, start, ce_toggle;
  logic tx, busy, done;
  logic [7:0] img [256];
  int cyc = 0;
  int checks = 0, failures = 0;

  logic [7:0] exp_q [$];
  frame_t     rx_q [$];
  int         done_q [$];
  int         rx_rd = 0;

  boot_image_sender_if #(.ADDR_W(AW)) bus ();

  boot_image_sender #(
    .CLKS_PER_BIT(CPB), .ADDR_W(AW), .IMAGE_LEN(LEN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .start(start),
    .tx   (tx),
    .busy (busy),
    .done (done),
    .mem  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_data <= img[bus.mem_addr];

  // ce changes just after the edge so it is stable for the whole cycle it gates
  initial begin
    ce = 1'b1;
    forever begin
      @(posedge clk);
      #1 ce = ce_toggle ? ~ce : 1'b1;
    end
  end

  // UART receiver: counts enabled cycles per bit and flags mid-bit changes
  logic       m_act = 1'b0, m_new, m_ok, m_val;
  logic [7:0] m_byte;
  int         m_bit, m_cnt, m_t;
  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_act = 1'b0;
      end else begin
        if (done === 1'b1) done_q.push_back(cyc);
        if (!m_act && tx === 1'b0) begin
          m_act = 1'b1; m_bit = 0; m_cnt = 0; m_new = 1'b1;
          m_ok = 1'b1; m_t = cyc; m_byte = '0;
        end
        if (m_act) begin
          if (m_new) begin
            m_val = tx; m_new = 1'b0;
          end else if (tx !== m_val) begin
            m_ok = 1'b0;
          end
          if (ce) m_cnt++;
          if (m_cnt == CPB) begin
            m_cnt = 0; m_new = 1'b1;
            if (m_bit == 0) begin
              if (m_val !== 1'b0) m_ok = 1'b0;
            end else if (m_bit <= 8) begin
              m_byte[m_bit-1] = m_val;
            end else begin
              if (m_val !== 1'b1) m_ok = 1'b0;
              f.data = m_byte; f.ok = m_ok; f.t = m_t;
              rx_q.push_back(f);
              m_act = 1'b0;
            end
            m_bit++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drain();
    frame_t f;
    logic [7:0] e;
    bit have;
    while (rx_rd < rx_q.size()) begin
      f = rx_q[rx_rd];
      rx_rd++;
      have = (exp_q.size() != 0);
      chk("frame_expected", have, 1);
      if (have) e = exp_q.pop_front(); else e = 'x;
      chk("frame_data", f.data, e);
      chk("frame_bit_timing", f.ok, 1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic push_image();
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < LEN; i++) begin
      exp_q.push_back(img[i]);
      s = s + img[i];
    end
`ifdef BOOT_IMAGE_SENDER_CHECKSUM_EN
    exp_q.push_back(8'(9'd256 - {1'b0, s}));
`endif
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0, i;
    n0 = done_q.size();
    i  = 0;
    while (done_q.size() == n0 && i < budget) begin
      step();
      i++;
    end
    chk(tag, done_q.size() > n0, 1);
  endtask

  initial begin
    int base, nd, t0;
    rst_n = 1'b0; start = 1'b0; ce_toggle = 1'b0;
    for (int i = 0; i < 256; i++) img[i] = 8'(i * 7 + 1);
    img[0] = 8'hA5; img[1] = 8'h3C; img[2] = 8'hFF;

    repeat (3) step();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_addr", bus.mem_addr, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // nominal image: cycle-exact framing
    base = rx_q.size(); nd = done_q.size();
    push_image();
    start = 1'b1; t0 = cyc;
    step();
    start = 1'b0;
    chk("c1_rd_en", bus.mem_rd_en, 1);
    chk("c1_addr", bus.mem_addr, 0);
    chk("c1_busy", busy, 1);
    chk("c1_tx", tx, 1);
    step();
    chk("c2_rd_en", bus.mem_rd_en, 0);
    chk("c2_tx", tx, 1);
    step();
    chk("c3_tx", tx, 0);
    wait_done("done_seen", 400);
    if (done_q.size() > nd) chk("done_cycle", done_q[nd] - t0, DONE_CYC);
    chk("frames_nominal", rx_q.size() - base, NFR);
    if (rx_q.size() >= base + NFR) begin
      chk("first_start_cycle", rx_q[base].t - t0, 3);
      chk("frame_len_1", rx_q[base+1].t - rx_q[base].t, FRAME_CYC);
      chk("frame_len_2", rx_q[base+2].t - rx_q[base+1].t, FRAME_CYC);
`ifdef BOOT_IMAGE_SENDER_CHECKSUM_EN
      chk("cksum_value", rx_q[base+3].data, 8'h20);
      chk("cksum_gap", rx_q[base+3].t - rx_q[base+2].t, 10 * CPB);
`endif
    end
    step();
    chk("done_low_after", done, 0);
    chk("busy_low_after", busy, 0);
    chk("addr_hold", bus.mem_addr, LEN - 1);
    chk("done_once", done_q.size() - nd, 1);
    chk("sb_empty_nominal", exp_q.size(), 0);

    // clock enable toggling every cycle
    base = rx_q.size();
    ce_toggle = 1'b1;
    push_image();
    start = 1'b1;
    repeat (2) step();
    start = 1'b0;
    wait_done("done_seen_ce", 800);
    repeat (2) step();
    ce_toggle = 1'b0;
    step();
    chk("frames_ce", rx_q.size() - base, NFR);
    chk("sb_empty_ce", exp_q.size(), 0);

    // start re-asserted mid-image is ignored
    base = rx_q.size(); nd = done_q.size();
    push_image();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (60) step();
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    wait_done("done_seen_mid", 400);
    repeat (150) step();
    chk("frames_mid", rx_q.size() - base, NFR);
    chk("done_once_mid", done_q.size() - nd, 1);
    chk("sb_empty_mid", exp_q.size(), 0);
    chk("busy_idle_mid", busy, 0);

    // asynchronous reset during the data bits of the second byte
    base = rx_q.size();
    push_image();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (59) step();
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_rd_en", bus.mem_rd_en, 0);
    chk("frames_before_reset", rx_q.size() - base, 1);
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    base = rx_q.size();
    push_image();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_rd_en", bus.mem_rd_en, 1);
    chk("restart_addr", bus.mem_addr, 0);
    wait_done("done_seen_restart", 400);
    step();
    chk("frames_restart", rx_q.size() - base, NFR);
    chk("sb_empty_restart", exp_q.size(), 0);

    // loopback of a random image into a receive RAM
    for (int i = 0; i < LEN; i++) img[i] = 8'($urandom);
    base = rx_q.size();
    push_image();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("done_seen_rand", 400);
    step();
    chk("frames_rand", rx_q.size() - base, NFR);
    if (rx_q.size() >= base + LEN)
      for (int i = 0; i < LEN; i++) chk("rx_ram", rx_q[base+i].data, img[i]);
    chk("sb_empty_rand", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
